// File: rtl/ecc_apb_master.sv
// ecc_apb_master: APB initiator that programs one ecc_enc_dec operation per command and
// returns its result. Define ECC_MST_READBACK_EN to add a register readback check after done.
module ecc_apb_master #(
  parameter int                         AMBA_ADDR_WIDTH = 20,
  parameter int                         AMBA_WORD       = 32,
  parameter int                         DATA_WIDTH      = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                         TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [31:0]                cmd_data,
  input  logic [31:0]                cmd_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_of_errors,
  output logic                       rsp_timeout,
  output logic                       rsp_rb_err
);

  localparam logic [1:0]  REG_CTRL  = 2'b00;
  localparam logic [1:0]  REG_DATA  = 2'b01;
  localparam logic [1:0]  REG_WIDTH = 2'b10;
  localparam logic [1:0]  REG_NOISE = 2'b11;
  localparam logic [15:0] TERMINAL  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCESS    = 3'd2,
    WAIT_DONE = 3'd3,
`ifdef ECC_MST_READBACK_EN
    RD_SETUP  = 3'd5,
    RD_ACCESS = 3'd6,
`endif
    RESP      = 3'd4
  } state_e;

  state_e      state_q;
  logic [1:0]  cmdOp_q;
  logic [1:0]  cmdWidth_q;
  logic [31:0] cmdData_q;
  logic [31:0] cmdNoise_q;
  logic [1:0]  regIdx_q;
  logic [15:0] waitCnt_q;
  logic [1:0]  nextReg;

  function automatic logic [AMBA_ADDR_WIDTH-1:0] regAddr(input logic [1:0] r);
    return BASE_ADDR | AMBA_ADDR_WIDTH'({r, 2'b00});
  endfunction

  function automatic logic [AMBA_WORD-1:0] regValue(input logic [1:0] r);
    case (r)
      REG_CTRL:  regValue = AMBA_WORD'(cmdOp_q);
      REG_DATA:  regValue = AMBA_WORD'(cmdData_q);
      REG_WIDTH: regValue = AMBA_WORD'(cmdWidth_q);
      default:   regValue = AMBA_WORD'(cmdNoise_q);
    endcase
  endfunction

  // Write order is WIDTH, NOISE (full-channel ops only), DATA, then CTRL which starts the engine.
  always_comb begin
    nextReg = REG_CTRL;
    case (regIdx_q)
      REG_WIDTH: nextReg = cmdOp_q[1] ? REG_NOISE : REG_DATA;
      REG_NOISE: nextReg = REG_DATA;
      default:   nextReg = REG_CTRL;
    endcase
  end

`ifdef ECC_MST_READBACK_EN
  logic rbErr_q;
  logic rbMismatch;
  assign rbMismatch = (PRDATA != regValue(regIdx_q)) && ((regIdx_q != REG_NOISE) || cmdOp_q[1]);
  assign rsp_rb_err = rbErr_q;
`else
  logic unusedPrdata;
  assign unusedPrdata = ^PRDATA;
  assign rsp_rb_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      cmdOp_q           <= '0;
      cmdWidth_q        <= '0;
      cmdData_q         <= '0;
      cmdNoise_q        <= '0;
      regIdx_q          <= '0;
      waitCnt_q         <= '0;
      cmd_ready         <= 1'b0;
      PADDR             <= '0;
      PWDATA            <= '0;
      PSEL              <= 1'b0;
      PENABLE           <= 1'b0;
      PWRITE            <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_num_of_errors <= '0;
      rsp_timeout       <= 1'b0;
`ifdef ECC_MST_READBACK_EN
      rbErr_q           <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmdOp_q     <= cmd_op;
            cmdWidth_q  <= cmd_width;
            cmdData_q   <= cmd_data;
            cmdNoise_q  <= cmd_noise;
            regIdx_q    <= REG_WIDTH;
            cmd_ready   <= 1'b0;
            PADDR       <= regAddr(REG_WIDTH);
            PWDATA      <= AMBA_WORD'(cmd_width);
            PSEL        <= 1'b1;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b1;
            rsp_timeout <= 1'b0;
`ifdef ECC_MST_READBACK_EN
            rbErr_q     <= 1'b0;
`endif
            state_q     <= SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (regIdx_q == REG_CTRL) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            waitCnt_q <= '0;
            state_q   <= WAIT_DONE;
          end else begin
            regIdx_q <= nextReg;
            PADDR    <= regAddr(nextReg);
            PWDATA   <= regValue(nextReg);
            PENABLE  <= 1'b0;
            state_q  <= SETUP;
          end
        end
        WAIT_DONE: begin
          // A done arriving on the terminal count still counts as success.
          if (operation_done) begin
            rsp_data          <= data_out;
            rsp_num_of_errors <= num_of_errors;
`ifdef ECC_MST_READBACK_EN
            regIdx_q          <= REG_CTRL;
            PADDR             <= regAddr(REG_CTRL);
            PSEL              <= 1'b1;
            PENABLE           <= 1'b0;
            PWRITE            <= 1'b0;
            state_q           <= RD_SETUP;
`else
            rsp_valid         <= 1'b1;
            state_q           <= RESP;
`endif
          end else if (waitCnt_q == TERMINAL) begin
            rsp_data          <= '0;
            rsp_num_of_errors <= '0;
            rsp_timeout       <= 1'b1;
            rsp_valid         <= 1'b1;
            state_q           <= RESP;
          end else begin
            waitCnt_q <= waitCnt_q + 16'd1;
          end
        end
`ifdef ECC_MST_READBACK_EN
        RD_SETUP: begin
          PENABLE <= 1'b1;
          state_q <= RD_ACCESS;
        end
        RD_ACCESS: begin
          rbErr_q <= rbErr_q | rbMismatch;
          PENABLE <= 1'b0;
          if (regIdx_q == REG_NOISE) begin
            PSEL      <= 1'b0;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            regIdx_q <= regIdx_q + 2'd1;
            PADDR    <= regAddr(regIdx_q + 2'd1);
            state_q  <= RD_SETUP;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_master.sv
// tb_ecc_apb_master: table-driven and randomized checks of ecc_apb_master against a behavioural
// model of the APB register sequence and response, with a stub ECC engine and APB slave.
`timescale 1ns/1ps
module tb_ecc_apb_master;

  localparam int T = 8;
`ifdef ECC_MST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef logic [52:0] xfer_t;  // {write, addr[19:0], data[31:0]}

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  width;
    logic [31:0] data;
    logic [31:0] noise;
    int          doneDelay;
    logic [31:0] dout;
    logic [1:0]  errs;
    bit          spurious;
    int          hold;
    bit          corrupt;
    logic [31:0] expData;
    logic [1:0]  expErrs;
    bit          expTmo;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_width = '0;
  logic [31:0] cmd_data = '0;
  logic [31:0] cmd_noise = '0;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA;
  logic        operation_done = 1'b0;
  logic [31:0] data_out = '0;
  logic [1:0]  num_of_errors = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_num_of_errors;
  logic        rsp_timeout;
  logic        rsp_rb_err;

  int errors = 0;
  int checks = 0;

  ecc_apb_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_width(cmd_width),
    .cmd_data(cmd_data), .cmd_noise(cmd_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_num_of_errors(rsp_num_of_errors), .rsp_timeout(rsp_timeout), .rsp_rb_err(rsp_rb_err)
  );

  always #5 clk = ~clk;

  // Stub APB slave register file plus an optional corrupted DATA_IN readback.
  logic [31:0] stubRegs [4] = '{default: 32'h0};
  bit          curCorrupt = 1'b0;
  assign PRDATA = (curCorrupt && PADDR[3:2] == 2'b01) ? 32'h6 : stubRegs[PADDR[3:2]];

  // Transfer monitor: records every completed APB transfer and checks SETUP/ACCESS pairing.
  xfer_t       seen[$];
  int          protoErrs = 0;
  bit          inSetup = 1'b0;
  logic [19:0] setupAddr;
  logic [31:0] setupData;
  always @(negedge clk) begin
    if (PSEL && !PENABLE) begin
      setupAddr = PADDR;
      setupData = PWDATA;
      inSetup   = 1'b1;
    end else if (PSEL && PENABLE) begin
      if (!inSetup || PADDR != setupAddr || (PWRITE && PWDATA != setupData)) protoErrs++;
      inSetup = 1'b0;
      seen.push_back({PWRITE, PADDR, PWRITE ? PWDATA : PRDATA});
      if (PWRITE) stubRegs[PADDR[3:2]] = PWDATA;
    end else begin
      inSetup = 1'b0;
    end
  end

  // Stub ECC engine: pulses done a programmed number of cycles into the wait after the CTRL write.
  int          curDoneDelay = -1;
  logic [31:0] curDout = '0;
  logic [1:0]  curErrs = '0;
  bit          spuriousArm = 1'b0;
  bit          armed = 1'b0;
  int          waitK = 0;
  always @(negedge clk) begin
    operation_done = 1'b0;
    data_out       = $urandom;
    num_of_errors  = 2'($urandom_range(0, 3));
    if (armed) begin
      if (waitK == curDoneDelay) begin
        operation_done = 1'b1;
        data_out       = curDout;
        num_of_errors  = curErrs;
        armed          = 1'b0;
      end
      waitK++;
      if (waitK > 20) armed = 1'b0;
    end
    if (spuriousArm && PSEL && !PENABLE && PWRITE) begin
      operation_done = 1'b1;
      data_out       = 32'hBAD0BAD0;
      num_of_errors  = 2'd3;
      spuriousArm    = 1'b0;
    end
    if (PSEL && PENABLE && PWRITE && PADDR[3:2] == 2'b00) begin
      armed = (curDoneDelay >= 0);
      waitK = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input int op, input int width, input logic [31:0] data,
                                 input logic [31:0] noise, input int delay, input logic [31:0] dout,
                                 input int errs, input bit spurious, input int hold, input bit corrupt,
                                 input logic [31:0] expData, input int expErrs, input bit expTmo);
    vec_t v;
    v.op = 2'(op); v.width = 2'(width); v.data = data; v.noise = noise;
    v.doneDelay = delay; v.dout = dout; v.errs = 2'(errs); v.spurious = spurious;
    v.hold = hold; v.corrupt = corrupt;
    v.expData = expData; v.expErrs = 2'(expErrs); v.expTmo = expTmo;
    return v;
  endfunction

  // Response model: done within the timeout window wins, otherwise an all-zero timeout response.
  function automatic vec_t modelRsp(input vec_t v);
    vec_t m = v;
    if (v.doneDelay < 0 || v.doneDelay >= T) begin
      m.expData = '0; m.expErrs = '0; m.expTmo = 1'b1;
    end else begin
      m.expData = v.dout; m.expErrs = v.errs; m.expTmo = 1'b0;
    end
    return m;
  endfunction

  logic [31:0] modelNoise = 32'h0;

  task automatic applyStimulus(input vec_t v, input string tag);
    int          n;
    int          lat;
    int          expLat;
    int          nXfer;
    bit          tmo;
    logic        expRb;
    logic [31:0] rbNoise;
    xfer_t       expQ[$];

    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checkOutput({tag, " cmd_ready idle"}, 64'(cmd_ready), 64'd1);

    tmo     = (v.doneDelay < 0) || (v.doneDelay >= T);
    rbNoise = v.op[1] ? v.noise : modelNoise;
    if (v.op[1]) modelNoise = v.noise;
    expQ.push_back({1'b1, 20'h8, 32'(v.width)});
    if (v.op[1]) expQ.push_back({1'b1, 20'hC, v.noise});
    expQ.push_back({1'b1, 20'h4, v.data});
    expQ.push_back({1'b1, 20'h0, 32'(v.op)});
    if (RB && !tmo) begin
      expQ.push_back({1'b0, 20'h0, 32'(v.op)});
      expQ.push_back({1'b0, 20'h4, v.corrupt ? 32'h6 : v.data});
      expQ.push_back({1'b0, 20'h8, 32'(v.width)});
      expQ.push_back({1'b0, 20'hC, rbNoise});
    end
    expRb  = RB && !tmo && v.corrupt && (v.data != 32'h6);
    expLat = 2 * (v.op[1] ? 4 : 3) + (tmo ? 1 + T : 2 + v.doneDelay + (RB ? 8 : 0));

    seen.delete();
    protoErrs    = 0;
    curDoneDelay = v.doneDelay;
    curDout      = v.dout;
    curErrs      = v.errs;
    spuriousArm  = v.spurious;
    curCorrupt   = v.corrupt;
    cmd_op = v.op; cmd_width = v.width; cmd_data = v.data; cmd_noise = v.noise;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput({tag, " cmd_ready busy"}, 64'(cmd_ready), 64'd0);

    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    checkOutput({tag, " rsp latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " xfer count"}, 64'(seen.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < seen.size(); i++)
      checkOutput($sformatf("%s xfer%0d", tag, i), 64'(seen[i]), 64'(expQ[i]));
    checkOutput({tag, " apb protocol"}, 64'(protoErrs), 64'd0);
    checkOutput({tag, " rsp_data"}, 64'(rsp_data), 64'(v.expData));
    checkOutput({tag, " rsp_errs"}, 64'(rsp_num_of_errors), 64'(v.expErrs));
    checkOutput({tag, " rsp_timeout"}, 64'(rsp_timeout), 64'(v.expTmo));
    checkOutput({tag, " rsp_rb_err"}, 64'(rsp_rb_err), 64'(expRb));

    nXfer = seen.size();
    for (int i = 0; i < v.hold; i++) begin
      if (i == v.hold / 2) begin
        cmd_op = 2'($urandom_range(0, 3)); cmd_data = $urandom; cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput($sformatf("%s hold%0d", tag, i),
                  64'({rsp_valid, cmd_ready, rsp_timeout, rsp_rb_err, rsp_num_of_errors, rsp_data}),
                  64'({1'b1, 1'b0, v.expTmo, expRb, v.expErrs, v.expData}));
    end
    checkOutput({tag, " no xfer in resp"}, 64'(seen.size()), 64'(nXfer));

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, " released"}, 64'({rsp_valid, cmd_ready}), 64'd1);
  endtask

  task automatic resetMidOp();
    int n;
    bit hit;
    curDoneDelay = 0; spuriousArm = 1'b0; curCorrupt = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    cmd_op = 2'b00; cmd_width = 2'b01; cmd_data = 32'h77; cmd_noise = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    hit = 1'b0; n = 0;
    while (!hit && n < 20) begin
      if (PSEL && PENABLE && PWRITE && PADDR[3:2] == 2'b01) hit = 1'b1;
      else begin @(negedge clk); n++; end
    end
    checkOutput("reset reached DATA_IN access", 64'(hit), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset apb bus zero", 64'({PADDR, PWDATA}), 64'd0);
    checkOutput("reset controls zero",
                64'({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_data, rsp_num_of_errors,
                     rsp_timeout, rsp_rb_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset cmd_ready back", 64'(cmd_ready), 64'd1);
    seen.delete();
    hit = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || PSEL) hit = 1'b1;
    end
    checkOutput("reset no response", 64'({hit, 32'(seen.size())}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset apb bus", 64'({PADDR, PWDATA}), 64'd0);
    checkOutput("reset outputs",
                64'({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_data, rsp_num_of_errors,
                     rsp_timeout, rsp_rb_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("cmd_ready after reset", 64'(cmd_ready), 64'd1);

    vecs.push_back(mkVec(0, 0, 32'h5,       32'hDEADBEEF, 2, 32'hA5,   0, 0, 0, 0, 32'hA5,   0, 0));
    vecs.push_back(mkVec(2, 2, 32'h1234567, 32'h1,        4, 32'hCAFE, 1, 0, 0, 0, 32'hCAFE, 1, 0));
    vecs.push_back(mkVec(1, 1, 32'h55,      32'h0,       -1, 32'h1,    0, 0, 0, 0, 32'h0,    0, 1));
    vecs.push_back(mkVec(3, 0, 32'h99,      32'hF0F0,     0, 32'h77,   2, 0, 5, 0, 32'h77,   2, 0));
    vecs.push_back(mkVec(1, 2, 32'h42,      32'h0,        7, 32'h3C3C, 3, 0, 1, 0, 32'h3C3C, 3, 0));
    vecs.push_back(mkVec(0, 1, 32'h10,      32'h0,        1, 32'h88,   1, 1, 0, 0, 32'h88,   1, 0));
    vecs.push_back(mkVec(2, 1, 32'hABC,     32'h5,        0, 32'h11,   0, 0, 0, 1, 32'h11,   0, 0));
    vecs.push_back(mkVec(0, 2, 32'hDEF,     32'h0,        3, 32'h22,   0, 0, 0, 0, 32'h22,   0, 0));
    for (int i = 0; i < 12; i++) begin
      vec_t r;
      r.op        = 2'($urandom_range(0, 3));
      r.width     = 2'($urandom_range(0, 2));
      r.data      = $urandom;
      r.noise     = $urandom;
      r.doneDelay = int'($urandom_range(0, 10)) - 1;
      r.dout      = $urandom;
      r.errs      = 2'($urandom_range(0, 3));
      r.spurious  = 1'($urandom_range(0, 1));
      r.hold      = int'($urandom_range(0, 3));
      r.corrupt   = 1'($urandom_range(0, 1));
      vecs.push_back(modelRsp(r));
    end

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    resetMidOp();
    applyStimulus(vecs[1], "after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
